busca_instrucao: RTL and testbench

Instruction fetch stage directly downstream of the program counter. Takes the current PC address and issues a request/acknowledge read to instruction memory. Stores returned instructions with their PC in a small in-order queue for decode. Throttles PC advance and discards in-flight fetches when a branch or jump redirects the PC.

---
 rtl/busca_instrucao_if.sv | 24 ++
 rtl/busca_instrucao.sv | 135 +++++++++++++
 tb/tb_busca_instrucao.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/busca_instrucao_if.sv
// busca_instrucao_if: fetch-stage bundle -- PC control, instruction memory req/ack bus
// and the decode-side queue head. master = fetch stage, slave = its surroundings.
interface busca_instrucao_if #(parameter int LARG_INST = 32);
    logic [63:0]          pc_endereco;
    logic                 redirect;
    logic                 pc_avanca;
    logic                 mem_req;
    logic [63:0]          mem_addr;
    logic                 mem_ack;
    logic [LARG_INST-1:0] mem_rdata;
    logic                 inst_valid;
    logic [LARG_INST-1:0] inst;
    logic [63:0]          inst_pc;
    logic                 inst_ready;
    logic                 erro_busca;
    modport master (
        input  pc_endereco, redirect, mem_ack, mem_rdata, inst_ready,
        output pc_avanca, mem_req, mem_addr, inst_valid, inst, inst_pc, erro_busca
    );
    modport slave (
        output pc_endereco, redirect, mem_ack, mem_rdata, inst_ready,
        input  pc_avanca, mem_req, mem_addr, inst_valid, inst, inst_pc, erro_busca
    );
endinterface

// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch with req/ack memory port and an in-order decode queue.
// Optional watchdog on outstanding fetches: define FETCH_TIMEOUT_EN.
module busca_instrucao #(
    parameter int PROFUNDIDADE = 2,
    parameter int LARG_INST    = 32,
    parameter int TIMEOUT      = 16
) (
    input logic clock,
    input logic reset,
    busca_instrucao_if.master io
);
    localparam int PW = $clog2(PROFUNDIDADE);
    localparam logic [PW:0] CHEIO = (PW+1)'(PROFUNDIDADE);

    if (PROFUNDIDADE < 2 || (PROFUNDIDADE & (PROFUNDIDADE - 1)) != 0 || TIMEOUT < 1) begin : g_param_chk
        $error("busca_instrucao: PROFUNDIDADE must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {OCIOSO, ESPERA, DESCARTA} estado_t;

    estado_t              estado_q, estado_d;
    logic                 mem_req_q, mem_req_d;
    logic [63:0]          mem_addr_q, mem_addr_d;
    logic [63:0]          req_pc_q, req_pc_d;
    logic                 pc_avanca_q, pc_avanca_d;
    logic [PW:0]          count_q, count_d;
    logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
    logic [LARG_INST-1:0] fila_inst_q [PROFUNDIDADE];
    logic [63:0]          fila_pc_q [PROFUNDIDADE];
    logic                 push, pop, timeout;

    always_comb begin
        estado_d    = estado_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        req_pc_d    = req_pc_q;
        pc_avanca_d = 1'b0;
        push        = 1'b0;
        pop         = (count_q != '0) && io.inst_ready;
        case (estado_q)
            OCIOSO: if (count_q < CHEIO && !io.redirect) begin
                estado_d   = ESPERA;
                mem_req_d  = 1'b1;
                mem_addr_d = io.pc_endereco;
                req_pc_d   = io.pc_endereco;
            end
            ESPERA: if (io.mem_ack) begin
                estado_d    = OCIOSO;
                mem_req_d   = 1'b0;
                push        = !io.redirect;
                pc_avanca_d = !io.redirect;
            end else if (io.redirect) begin
                estado_d = DESCARTA;
            end
            DESCARTA: if (io.mem_ack) begin
                estado_d  = OCIOSO;
                mem_req_d = 1'b0;
            end
            default: estado_d = OCIOSO;
        endcase
        // The watchdog abandons the request without pushing anything.
        if (timeout) begin
            estado_d  = OCIOSO;
            mem_req_d = 1'b0;
        end
        count_d = io.redirect ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
        rd_d    = io.redirect ? '0 : rd_q + PW'(pop);
        wr_d    = io.redirect ? '0 : wr_q + PW'(push);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            req_pc_q    <= '0;
            pc_avanca_q <= 1'b0;
            count_q     <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
        end else begin
            estado_q    <= estado_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            req_pc_q    <= req_pc_d;
            pc_avanca_q <= pc_avanca_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
        end
    end

    // Storage needs no reset: the outputs are masked while the queue is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            fila_inst_q[wr_q] <= io.mem_rdata;
            fila_pc_q[wr_q]   <= req_pc_q;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr_q, tmr_d;
    logic          erro_q, erro_d, aguarda;

    always_comb begin
        aguarda = estado_q != OCIOSO;
        timeout = aguarda && !io.mem_ack && !io.redirect && tmr_q == TW'(TIMEOUT - 1);
        tmr_d   = (aguarda && !io.mem_ack && !io.redirect && !timeout) ? tmr_q + 1'b1 : '0;
        erro_d  = erro_q | timeout;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmr_q  <= '0;
            erro_q <= 1'b0;
        end else begin
            tmr_q  <= tmr_d;
            erro_q <= erro_d;
        end
    end

    assign io.erro_busca = erro_q;
`else
    assign timeout       = 1'b0;
    assign io.erro_busca = 1'b0;
`endif

    assign io.mem_req    = mem_req_q;
    assign io.mem_addr   = mem_addr_q;
    assign io.pc_avanca  = pc_avanca_q;
    assign io.inst_valid = count_q != '0;
    assign io.inst       = io.inst_valid ? fila_inst_q[rd_q] : '0;
    assign io.inst_pc    = io.inst_valid ? fila_pc_q[rd_q] : '0;
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed fetch scenarios; every instruction dequeued by decode is
// compared by a monitor against a queue of expected {inst, pc} pairs.
`timescale 1ns/1ps
module tb_busca_instrucao;
    localparam int LI = 32;

    typedef struct packed {
        logic [LI-1:0] inst;
        logic [63:0]   pc;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ent_t exp_q[$];

    busca_instrucao_if #(.LARG_INST(LI)) io ();

    busca_instrucao #(.PROFUNDIDADE(2), .LARG_INST(LI), .TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic nxt();
        @(negedge clock);
    endtask

    // Drive one ack cycle; returns on the following negedge with ack released.
    task automatic ack(input logic [LI-1:0] d, input logic [63:0] pc, input bit enq);
        io.mem_ack   = 1'b1;
        io.mem_rdata = d;
        if (enq) exp_q.push_back('{inst: d, pc: pc});
        nxt();
        io.mem_ack   = 1'b0;
        io.mem_rdata = '0;
    endtask

    // Scoreboard monitor: inputs change on negedge, so sample 1ns later for the next posedge.
    always begin
        ent_t e;
        @(negedge clock);
        #1;
        if (reset && io.inst_valid && io.inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got inst %0h pc %0h expected no entry", io.inst, io.inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_inst", io.inst, e.inst);
                chk("pop_pc", io.inst_pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        io.pc_endereco = 64'h10;
        io.redirect    = 1'b0;
        io.mem_ack     = 1'b0;
        io.mem_rdata   = '0;
        io.inst_ready  = 1'b0;
        nxt();
        nxt();
        chk("rst_mem_req", io.mem_req, 0);
        chk("rst_mem_addr", io.mem_addr, 0);
        chk("rst_pc_avanca", io.pc_avanca, 0);
        chk("rst_inst_valid", io.inst_valid, 0);
        chk("rst_inst", io.inst, 0);
        chk("rst_inst_pc", io.inst_pc, 0);
        chk("rst_erro", io.erro_busca, 0);
        reset = 1'b1;

        // 1: first fetch, ack two cycles after the request
        nxt();
        chk("t1_req", io.mem_req, 1);
        chk("t1_addr", io.mem_addr, 64'h10);
        nxt();
        chk("t1_req_held", io.mem_req, 1);
        ack(32'h00500093, 64'h10, 1);
        chk("t1_avanca", io.pc_avanca, 1);
        chk("t1_valid", io.inst_valid, 1);
        chk("t1_inst", io.inst, 32'h00500093);
        chk("t1_inst_pc", io.inst_pc, 64'h10);
        chk("t1_req_drop", io.mem_req, 0);
        io.pc_endereco = 64'h20;
        io.inst_ready  = 1'b1;
        nxt();
        io.inst_ready = 1'b0;
        chk("t1_avanca_once", io.pc_avanca, 0);
        chk("t2_empty", io.inst_valid, 0);

        // 2: fill the queue with 0x20 and 0x21, then free one slot
        chk("t2_req_a", io.mem_req, 1);
        chk("t2_addr_a", io.mem_addr, 64'h20);
        ack(32'h11111111, 64'h20, 1);
        io.pc_endereco = 64'h21;
        nxt();
        chk("t2_req_b", io.mem_req, 1);
        chk("t2_addr_b", io.mem_addr, 64'h21);
        ack(32'h22222222, 64'h21, 1);
        io.pc_endereco = 64'h22;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("t2_full_noreq", io.mem_req, 0);
        end
        chk("t2_head_pc", io.inst_pc, 64'h20);
        io.inst_ready = 1'b1;
        nxt();
        io.inst_ready = 1'b0;
        chk("t2_head_after_pop", io.inst_pc, 64'h21);
        chk("t2_noreq_yet", io.mem_req, 0);
        nxt();
        chk("t2_req_after_pop", io.mem_req, 1);
        chk("t2_addr_after_pop", io.mem_addr, 64'h22);

        // 3: redirect while waiting, late ack must be discarded
        io.redirect    = 1'b1;
        io.pc_endereco = 64'h100;
        exp_q.delete();
        nxt();
        io.redirect = 1'b0;
        chk("t3_flush", io.inst_valid, 0);
        chk("t3_inst_zero", io.inst, 0);
        chk("t3_inst_pc_zero", io.inst_pc, 0);
        chk("t3_req_held", io.mem_req, 1);
        chk("t3_addr_held", io.mem_addr, 64'h22);
        ack(32'hDEADBEEF, 64'h0, 0);
        chk("t3_no_avanca", io.pc_avanca, 0);
        chk("t3_not_enq", io.inst_valid, 0);
        chk("t3_req_drop", io.mem_req, 0);
        nxt();
        chk("t3_new_req", io.mem_req, 1);
        chk("t3_new_addr", io.mem_addr, 64'h100);

        // 4: redirect coinciding with ack while entries are queued
        ack(32'h33333333, 64'h100, 1);
        io.pc_endereco = 64'h101;
        nxt();
        chk("t4_addr_b", io.mem_addr, 64'h101);
        ack(32'h44444444, 64'h101, 1);
        io.pc_endereco = 64'h102;
        io.inst_ready  = 1'b1;
        nxt();
        io.inst_ready = 1'b0;
        chk("t4_full_noreq", io.mem_req, 0);
        nxt();
        chk("t4_req_c", io.mem_req, 1);
        chk("t4_valid_before", io.inst_valid, 1);
        io.redirect    = 1'b1;
        io.pc_endereco = 64'h200;
        exp_q.delete();
        ack(32'h55555555, 64'h0, 0);
        io.redirect = 1'b0;
        chk("t4_flush", io.inst_valid, 0);
        chk("t4_req_drop", io.mem_req, 0);
        chk("t4_no_avanca", io.pc_avanca, 0);
        nxt();
        chk("t4_idle_req", io.mem_req, 1);
        chk("t4_idle_addr", io.mem_addr, 64'h200);

        // 5: push and pop on the same edge with one entry queued
        ack(32'h66666666, 64'h200, 1);
        io.pc_endereco = 64'h201;
        nxt();
        chk("t5_addr", io.mem_addr, 64'h201);
        chk("t5_head_old", io.inst_pc, 64'h200);
        io.inst_ready = 1'b1;
        ack(32'h77777777, 64'h201, 1);
        io.inst_ready = 1'b0;
        chk("t5_valid", io.inst_valid, 1);
        chk("t5_head_new", io.inst, 32'h77777777);
        io.pc_endereco = 64'h202;
        io.inst_ready  = 1'b1;
        nxt();
        io.inst_ready = 1'b0;
        chk("t5_count_was_one", io.inst_valid, 0);
        chk("t5_req_next", io.mem_req, 1);
        chk("t5_addr_next", io.mem_addr, 64'h202);

        // 6: outstanding request with no ack
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            nxt();
            chk("t6_req_wait", io.mem_req, 1);
        end
        nxt();
        chk("t6_req_timeout", io.mem_req, 0);
        chk("t6_erro", io.erro_busca, 1);
        for (int i = 0; i < 12; i++) nxt();
        chk("t6_erro_sticky", io.erro_busca, 1);
`else
        for (int i = 0; i < 20; i++) nxt();
        chk("t6_req_waits", io.mem_req, 1);
        chk("t6_addr_held", io.mem_addr, 64'h202);
        chk("t6_erro_tied", io.erro_busca, 0);
`endif

        // reset in the middle of a request abandons it
        reset = 1'b0;
        #1;
        chk("t7_rst_req", io.mem_req, 0);
        chk("t7_rst_erro", io.erro_busca, 0);
        chk("t7_rst_valid", io.inst_valid, 0);
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
